// File: rtl/mem_arbiter.sv
// Main-memory arbiter for I-fill, D-fill and write-through stores.
// One owner at a time; every grant returns through IDLE; fill grants are bounded by a watchdog.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_done,
  output logic        i_grant,
  output logic        i_data_valid,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        d_done,
  output logic        d_grant,
  output logic        d_data_valid,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_enable,
  output logic        mem_wr,
  input  logic        mem_data_valid,
  output logic        timeout_err
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } state_e;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  state_e          state_q, state_d;
  src_e            last_fill_q, last_fill_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            fill_req, fill_done, wd_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_fill_q <= SRC_I;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_fill_q <= last_fill_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_fill_d  = last_fill_q;
    wd_cnt_d     = '0;
    fill_req     = (state_q == FILL_D) ? d_req  : i_req;
    fill_done    = (state_q == FILL_D) ? d_done : i_done;
    wd_hit       = (wd_cnt_q == WD_LAST);
    i_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_grant      = 1'b0;
    d_data_valid = 1'b0;
    wr_ack       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    timeout_err  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = WRITE;
        end else if (i_req && d_req) begin
          state_d = (last_fill_q == SRC_I) ? FILL_D : FILL_I;
        end else if (d_req) begin
          state_d = FILL_D;
        end else if (i_req) begin
          state_d = FILL_I;
        end
      end

      WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = wr_addr;
        mem_wdata  = wr_data;
        wr_ack     = 1'b1;
        state_d    = IDLE;
      end

      FILL_I, FILL_D: begin
        mem_enable = 1'b1;
        if (state_q == FILL_I) begin
          i_grant      = 1'b1;
          i_data_valid = mem_data_valid;
          mem_addr     = i_addr;
        end else begin
          d_grant      = 1'b1;
          d_data_valid = mem_data_valid;
          mem_addr     = d_addr;
        end
        // A done or abort in the watchdog's last cycle is reported as a normal exit.
        timeout_err = wd_hit && fill_req && !fill_done;
        if (fill_done || !fill_req || wd_hit) begin
          state_d = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_q == IDLE && state_d == FILL_I) last_fill_d = SRC_I;
    if (state_q == IDLE && state_d == FILL_D) last_fill_d = SRC_D;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: ownership-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, i_done = 1'b0, d_req = 1'b0, d_done = 1'b0;
  logic        wr_req = 1'b0, mem_data_valid = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, wr_addr = '0, wr_data = '0;
  logic        i_grant, i_data_valid, d_grant, d_data_valid, wr_ack;
  logic        mem_enable, mem_wr, timeout_err;
  logic [15:0] mem_addr, mem_wdata;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .i_grant(i_grant), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_addr(d_addr), .d_done(d_done),
    .d_grant(d_grant), .d_data_valid(d_data_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_enable(mem_enable),
    .mem_wr(mem_wr), .mem_data_valid(mem_data_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns memory, how long the current fill has held it,
  // and which fill source was served most recently.
  typedef enum int {OWN_NONE, OWN_I, OWN_D, OWN_WR} owner_t;
  owner_t owner = OWN_NONE;
  bit     last_was_d = 1'b0;
  int     held = 0;

  always @(posedge clk or negedge rst_n) begin : model
    owner_t nxt;
    bit     rq, dn;
    if (!rst_n) begin
      owner      <= OWN_NONE;
      last_was_d <= 1'b0;
      held       <= 0;
    end else begin
      nxt = owner;
      rq  = (owner == OWN_I) ? i_req  : d_req;
      dn  = (owner == OWN_I) ? i_done : d_done;
      case (owner)
        OWN_NONE: begin
          if (wr_req)              nxt = OWN_WR;
          else if (i_req && d_req) nxt = last_was_d ? OWN_I : OWN_D;
          else if (d_req)          nxt = OWN_D;
          else if (i_req)          nxt = OWN_I;
        end
        OWN_WR: nxt = OWN_NONE;
        default: if (dn || !rq || held == int'(TIMEOUT) - 1) nxt = OWN_NONE;
      endcase
      owner <= nxt;
      held  <= (owner != OWN_NONE && owner != OWN_WR && nxt == owner) ? held + 1 : 0;
      if (owner == OWN_NONE && nxt == OWN_D) last_was_d <= 1'b1;
      if (owner == OWN_NONE && nxt == OWN_I) last_was_d <= 1'b0;
    end
  end

  function automatic logic [39:0] model_out();
    logic ig, idv, dg, ddv, ack, en, wr, to;
    logic [15:0] a, wd;
    {ig, idv, dg, ddv, ack, en, wr, to} = '0;
    a  = '0;
    wd = '0;
    case (owner)
      OWN_I: begin
        ig = 1'b1; idv = mem_data_valid; en = 1'b1; a = i_addr;
        to = (held == int'(TIMEOUT) - 1) && i_req && !i_done;
      end
      OWN_D: begin
        dg = 1'b1; ddv = mem_data_valid; en = 1'b1; a = d_addr;
        to = (held == int'(TIMEOUT) - 1) && d_req && !d_done;
      end
      OWN_WR: begin
        ack = 1'b1; en = 1'b1; wr = 1'b1; a = wr_addr; wd = wr_data;
      end
      default: ;
    endcase
    return {ig, idv, dg, ddv, ack, en, wr, to, a, wd};
  endfunction

  function automatic logic [39:0] dut_out();
    return {i_grant, i_data_valid, d_grant, d_data_valid, wr_ack,
            mem_enable, mem_wr, timeout_err, mem_addr, mem_wdata};
  endfunction

  always @(negedge clk) begin : compare
    logic [39:0] e, a;
    e = model_out();
    a = dut_out();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t: got %h expected %h", $time, a, e);
    end
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk); #1;
  endtask

  int g, t, g_at_to;
  bit no_done;

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset, then abort a D fill with an asynchronous reset.
    repeat (3) tick();
    rst_n = 1'b1;
    samp(); chk("reset_idle", dut_out(), 40'h0);
    tick();
    d_req = 1'b1; d_addr = 16'h5550;
    tick();
    samp(); chk("pre_rst_d_grant", d_grant, 1'b1);
    tick(); #2;
    rst_n = 1'b0; #1;
    chk("rst_all_zero", dut_out(), 40'h0);
    tick();
    rst_n = 1'b1; d_req = 1'b0;
    samp(); chk("post_rst_idle", {d_grant, mem_enable}, 2'b00);
    tick();

    // Lone I miss.
    i_req = 1'b1; i_addr = 16'h1230;
    samp(); chk("i_grant_latency", i_grant, 1'b0);
    tick();
    samp(); chk("i_grant", i_grant, 1'b1);
    chk("i_mem_addr", mem_addr, 16'h1230);
    chk("i_mem_wr", {mem_enable, mem_wr}, 2'b10);
    for (int k = 0; k < 8; k++) begin
      tick();
      mem_data_valid = 1'b1;
      samp(); chk("i_valid_steer", {i_data_valid, d_data_valid}, 2'b10);
    end
    mem_data_valid = 1'b0; i_done = 1'b1;
    tick();
    i_done = 1'b0; i_req = 1'b0;
    samp(); chk("i_done_idle", {i_grant, mem_enable}, 2'b00);
    tick();

    // Both fills requesting: alternation starting with D.
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h2000; d_addr = 16'h3000;
    tick();
    samp(); chk("alt_first_d", {i_grant, d_grant}, 2'b01);
    d_done = 1'b1;
    tick();
    d_done = 1'b0;
    samp(); chk("alt_gap1", {i_grant, d_grant}, 2'b00);
    tick();
    samp(); chk("alt_then_i", {i_grant, d_grant, mem_addr}, {2'b10, 16'h2000});
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    samp(); chk("alt_gap2", {i_grant, d_grant}, 2'b00);
    tick();
    samp(); chk("alt_then_d", {i_grant, d_grant}, 2'b01);
    d_done = 1'b1; i_req = 1'b0;
    tick();
    d_done = 1'b0; d_req = 1'b0;
    tick();

    // Store priority over a pending fill, then a store arriving mid-fill.
    wr_req = 1'b1; wr_addr = 16'h00A0; wr_data = 16'hBEEF; d_req = 1'b1; d_addr = 16'h4000;
    samp(); chk("wr_idle_noack", wr_ack, 1'b0);
    tick();
    samp(); chk("wr_cycle", {wr_ack, mem_enable, mem_wr, mem_addr, mem_wdata},
                {3'b111, 16'h00A0, 16'hBEEF});
    tick();
    wr_req = 1'b0;
    samp(); chk("wr_then_idle", {d_grant, mem_enable}, 2'b00);
    tick();
    samp(); chk("wr_then_fill_d", {d_grant, mem_addr}, {1'b1, 16'h4000});
    wr_req = 1'b1; wr_addr = 16'h00B0; wr_data = 16'h1234;
    tick();
    samp(); chk("wr_waits_fill", {d_grant, wr_ack}, 2'b10);
    d_done = 1'b1;
    tick();
    d_done = 1'b0; d_req = 1'b0;
    samp(); chk("wr_wait_idle", {d_grant, wr_ack}, 2'b00);
    tick();
    samp(); chk("wr_late_served", {wr_ack, mem_addr, mem_wdata}, {1'b1, 16'h00B0, 16'h1234});
    tick();
    wr_req = 1'b0;
    tick();

    // Watchdog release of a fill that never completes.
    i_req = 1'b1; i_addr = 16'h7700;
    tick();
    g = 0; t = 0; g_at_to = 0;
    for (int k = 0; k < 200; k++) begin
      samp();
      if (i_grant) g++;
      if (timeout_err) begin
        t++; g_at_to = g;
        tick();
        i_req = 1'b0;
        break;
      end
      tick();
    end
    chk("wd_grant_cycles", g, TIMEOUT);
    chk("wd_pulse_count", t, 1);
    chk("wd_pulse_on_last", g_at_to, TIMEOUT);
    samp(); chk("wd_idle", {i_grant, timeout_err, mem_enable}, 3'b000);
    tick();

    // Data valid outside fills is discarded; D abort mid-fill.
    mem_data_valid = 1'b1;
    samp(); chk("dv_idle", {i_data_valid, d_data_valid}, 2'b00);
    wr_req = 1'b1;
    tick();
    samp(); chk("dv_write", {i_data_valid, d_data_valid, wr_ack}, 3'b001);
    wr_req = 1'b0; d_req = 1'b1;
    tick();
    samp(); chk("dv_idle2", {i_data_valid, d_data_valid}, 2'b00);
    tick();
    samp(); chk("dv_fill_d", {i_data_valid, d_data_valid}, 2'b01);
    d_req = 1'b0;
    tick();
    samp(); chk("d_abort_idle", {d_grant, mem_enable}, 2'b00);
    mem_data_valid = 1'b0;
    tick();

    // Randomized traffic against the model, including a done-free window and an async reset.
    for (int c = 0; c < 4000; c++) begin
      no_done = (c >= 2000 && c < 2600);
      i_req  = i_req ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
      d_req  = d_req ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
      if (no_done) begin
        i_req = 1'b1; d_req = 1'b1;
      end
      i_done = !no_done && ($urandom_range(0, 9) == 0);
      d_done = !no_done && ($urandom_range(0, 9) == 0);
      wr_req = (!no_done && $urandom_range(0, 7) == 0) || (wr_req && $urandom_range(0, 3) != 0);
      mem_data_valid = $urandom_range(0, 1) == 1;
      i_addr  = 16'($urandom);
      d_addr  = 16'($urandom);
      wr_addr = 16'($urandom);
      wr_data = 16'($urandom);
      if (c == 3000) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    i_req = 1'b0; d_req = 1'b0; wr_req = 1'b0; i_done = 1'b0; d_done = 1'b0;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
